serial_async_tx_buf: RTL and testbench
======================================

SERIAL_ASYNC_TX_BUF -- requirements
Module: serial_async_tx_buf

Interface
REQ-001 SHALL have parameter BITS, default 8, data bits per frame (5..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, buffered words (power of two, >=2).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1..2).
REQ-004 SHALL have parameter LOWBIT_FIRST, default 1'b1, 1 = LSB transmitted first, 0 = MSB first.
REQ-005 SHALL have port serial_clk  in  1  bit-rate clock, all logic on rising edge.
REQ-006 SHALL have port in_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_wr  in  1  write strobe, one word per asserted edge.
REQ-008 SHALL have port in_data  in  BITS  word to enqueue.
REQ-009 SHALL have port in_parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (constant 1).
REQ-010 SHALL have port out_serial  out  1  serial line, idle high.
REQ-011 SHALL have port out_busy  out  1  frame in progress (state != Idle).
REQ-012 SHALL have port out_full / out_empty  out  1 each  FIFO status.
REQ-013 SHALL have port out_level  out  $clog2(FIFO_DEPTH)+1  words in FIFO.
REQ-014 SHALL have port out_overflow  out  1  sticky, write attempted while full.
REQ-015 SHALL have port out_word_done  out  1  high during last stop-bit cycle of each frame.

Function
REQ-016 FIFO write SHALL occur at edge when in_wr=1 and out_full=0; write while full SHALL be dropped and set out_overflow.
REQ-017 Simultaneous write and pop SHALL leave out_level unchanged; write while full SHALL be dropped even with a concurrent pop.
REQ-018 Read/write pointers SHALL wrap modulo FIFO_DEPTH; out_full = (level==FIFO_DEPTH), out_empty = (level==0).
REQ-019 FSM states: Idle, Start, Data, Parity, Stop; out_serial driven combinationally from state: Idle 1, Start 0, Data current bit, Parity parity bit, Stop 1.
REQ-020 Idle: if out_empty=0 at edge, pop head word into shift register, latch in_parity_mode, go Start; else stay Idle.
REQ-021 Start: 1 cycle, then Data with bit counter 0.
REQ-022 Data: BITS cycles, bit order per LOWBIT_FIRST; then Parity if latched mode != 00, else Stop.
REQ-023 Parity: 1 cycle; even = XOR of data, odd = inverted XOR, mark = 1; computed from word latched at pop.
REQ-024 Stop: STOP_BITS cycles; on last cycle out_word_done=1; at end, if FIFO non-empty pop and go Start directly (no idle cycle), else Idle.
REQ-025 Frame length SHALL be 1+BITS+(mode!=00)+STOP_BITS cycles; back-to-back frames SHALL have no gap.
REQ-026 Latency: word written at edge k into empty FIFO with FSM Idle -> start bit on out_serial from edge k+1 to k+2.
REQ-027 in_parity_mode changes mid-frame SHALL not affect the current frame.
REQ-028 Pop in Idle and write in same edge with level 0 SHALL not occur (pop needs level>0 before edge); written word pops next edge.

Reset
REQ-029 in_rst=1 SHALL asynchronously force: state Idle, out_serial 1, out_busy 0, out_level 0, out_empty 1, out_full 0, out_overflow 0, out_word_done 0, pointers and counters 0.
REQ-030 Reset mid-frame SHALL abort the frame and discard FIFO contents; no partial frame resumes after release.

Verification
REQ-031 BITS=8, mode 00, write 0xA5 while idle -> line 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), out_word_done on stop cycle, out_busy low after.
REQ-032 mode 01 with 0x07, then mode 10 with 0x07 -> parity bits 1 then 0; mode 11 -> 1; frame length 11 cycles.
REQ-033 Write 3 words in consecutive cycles -> three contiguous frames, no idle cycle between stop and next start, out_level 2,1,0 sequence.
REQ-034 FIFO_DEPTH=4, write 6 words in 6 consecutive cycles while idle -> first pops after cycle 1, out_full seen, one dropped write, out_overflow=1, 5 frames sent.
REQ-035 Assert in_rst during Data bit 3 -> out_serial 1 immediately, level 0, no further frames after release.
REQ-036 LOWBIT_FIRST=0, STOP_BITS=2, 0x80 -> line 0,1,0,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/serial_async_tx_buf.sv
// ---------------------------------------------------------------------------
// serial_async_tx_buf
//   Buffered asynchronous serial transmitter. Words are queued in a small
//   FIFO and shifted out one bit per serial_clk cycle as
//   start(0) + data + optional parity + stop(1) frames. Frames are sent
//   back to back while words remain queued.
//
// Ports
//   serial_clk      in   bit-rate clock, rising edge
//   in_rst          in   asynchronous active-high reset
//   in_wr           in   write strobe, one word per asserted edge
//   in_data         in   word to enqueue [BITS]
//   in_parity_mode  in   00 none, 01 even, 10 odd, 11 mark
//   out_serial      out  serial line, idle high
//   out_busy        out  frame in progress
//   out_full        out  FIFO holds FIFO_DEPTH words
//   out_empty       out  FIFO holds no words
//   out_level       out  words in FIFO
//   out_overflow    out  sticky, write attempted while full
//   out_word_done   out  high during the last stop-bit cycle of a frame
//
// FSM states
//   state    | meaning
//   S_IDLE   | line high, waiting for a queued word
//   S_START  | start bit (0), one cycle
//   S_DATA   | BITS data bits, order set by LOWBIT_FIRST
//   S_PARITY | parity bit, only when the latched mode is not 00
//   S_STOP   | STOP_BITS stop bits (1); last one may pop the next word
// ---------------------------------------------------------------------------
module serial_async_tx_buf #(
    parameter int   BITS         = 8,
    parameter int   FIFO_DEPTH   = 16,
    parameter int   STOP_BITS    = 1,
    parameter logic LOWBIT_FIRST = 1'b1
) (
    input  logic                          serial_clk,
    input  logic                          in_rst,
    input  logic                          in_wr,
    input  logic [BITS-1:0]               in_data,
    input  logic [1:0]                    in_parity_mode,
    output logic                          out_serial,
    output logic                          out_busy,
    output logic                          out_full,
    output logic                          out_empty,
    output logic [$clog2(FIFO_DEPTH):0]   out_level,
    output logic                          out_overflow,
    output logic                          out_word_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BITS + 1);

    localparam logic [LW-1:0] C_DEPTH     = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_DATA_LAST = CW'(BITS - 1);
    localparam logic [CW-1:0] C_STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BITS-1:0] r_shift;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_mode;
    logic            r_par_bit;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_en;
    logic            w_pop;
    logic            w_shift;
    logic            w_cnt_ld_data;
    logic            w_cnt_ld_stop;
    logic            w_cnt_dec;
    logic            w_cnt_tc;
    logic [BITS-1:0] w_head;
    logic            w_par_nxt;
    logic            w_data_bit;

    assign w_full   = (r_level == C_DEPTH);
    assign w_empty  = (r_level == '0);
    // Full is judged before the edge, so a concurrent pop never rescues a write.
    assign w_wr_en  = in_wr && !w_full;
    assign w_cnt_tc = (r_cnt == '0);
    assign w_head   = r_mem[r_rd_ptr];

    // Parity is fixed at pop time from the word and the mode sampled then.
    always_comb begin
        w_par_nxt = 1'b0;
        case (in_parity_mode)
            2'b01:   w_par_nxt = ^w_head;
            2'b10:   w_par_nxt = ~^w_head;
            2'b11:   w_par_nxt = 1'b1;
            default: w_par_nxt = 1'b0;
        endcase
    end

    assign w_data_bit = LOWBIT_FIRST ? r_shift[0] : r_shift[BITS-1];

    // ---------------- FIFO ----------------
    always_ff @(posedge serial_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (in_wr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_shift       = 1'b0;
        w_cnt_ld_data = 1'b0;
        w_cnt_ld_stop = 1'b0;
        w_cnt_dec     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_ld_data = 1'b1;
                w_state_nxt   = S_DATA;
            end
            S_DATA: begin
                if (w_cnt_tc) begin
                    if (r_mode != 2'b00) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_cnt_ld_stop = 1'b1;
                        w_state_nxt   = S_STOP;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                    w_shift   = 1'b1;
                end
            end
            S_PARITY: begin
                w_cnt_ld_stop = 1'b1;
                w_state_nxt   = S_STOP;
            end
            S_STOP: begin
                if (w_cnt_tc) begin
                    // Chain straight into the next frame when a word is waiting.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_shift   <= '0;
            r_mode    <= 2'b00;
            r_par_bit <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_pop) begin
                r_shift   <= w_head;
                r_mode    <= in_parity_mode;
                r_par_bit <= w_par_nxt;
            end else if (w_shift) begin
                r_shift <= LOWBIT_FIRST ? (r_shift >> 1) : (r_shift << 1);
            end
            if (w_cnt_ld_data) begin
                r_cnt <= C_DATA_LAST;
            end else if (w_cnt_ld_stop) begin
                r_cnt <= C_STOP_LAST;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        out_serial = 1'b1;
        case (r_state)
            S_IDLE:   out_serial = 1'b1;
            S_START:  out_serial = 1'b0;
            S_DATA:   out_serial = w_data_bit;
            S_PARITY: out_serial = r_par_bit;
            S_STOP:   out_serial = 1'b1;
            default:  out_serial = 1'b1;
        endcase
    end

    assign out_busy      = (r_state != S_IDLE);
    assign out_full      = w_full;
    assign out_empty     = w_empty;
    assign out_level     = r_level;
    assign out_overflow  = r_overflow;
    assign out_word_done = (r_state == S_STOP) && w_cnt_tc;

endmodule

// File: tb/tb_serial_async_tx_buf.sv
module tb_serial_async_tx_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr;
    logic [7:0] din;
    logic [1:0] mode;

    logic       ser_a, busy_a, full_a, empty_a, ovf_a, done_a;
    logic [2:0] lvl_a;
    logic       ser_b, busy_b, full_b, empty_b, ovf_b, done_b;
    logic [4:0] lvl_b;

    int checks = 0;
    int errors = 0;

    // dut_a: depth 4, LSB first, one stop bit. dut_b: depth 16, MSB first, two stop bits.
    serial_async_tx_buf #(.BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1), .LOWBIT_FIRST(1'b1)) dut_a (
        .serial_clk(clk), .in_rst(rst), .in_wr(wr), .in_data(din), .in_parity_mode(mode),
        .out_serial(ser_a), .out_busy(busy_a), .out_full(full_a), .out_empty(empty_a),
        .out_level(lvl_a), .out_overflow(ovf_a), .out_word_done(done_a));

    serial_async_tx_buf #(.BITS(8), .FIFO_DEPTH(16), .STOP_BITS(2), .LOWBIT_FIRST(1'b0)) dut_b (
        .serial_clk(clk), .in_rst(rst), .in_wr(wr), .in_data(din), .in_parity_mode(mode),
        .out_serial(ser_b), .out_busy(busy_b), .out_full(full_b), .out_empty(empty_b),
        .out_level(lvl_b), .out_overflow(ovf_b), .out_word_done(done_b));

    // ---------------- behavioural model ----------------
    // Each instance: a word queue plus the list of line bits still to be sent
    // for the frame in flight (element 0 is what the line shows right now).
    int         p_depth [2] = '{4, 16};
    int         p_stop  [2] = '{1, 2};
    bit         p_lsb   [2] = '{1'b1, 1'b0};
    logic [7:0] mq   [2][16];
    int         mq_n [2];
    bit         mf   [2][24];
    int         mf_n [2];
    bit         m_ovf[2];

    task automatic model_step(input int i);
        bit         full;
        bit         take;
        logic [7:0] w;
        bit         fb [24];
        int         n;
        if (mf_n[i] > 0) begin
            for (int j = 0; j < 23; j++) mf[i][j] = mf[i][j+1];
            mf_n[i] = mf_n[i] - 1;
        end
        full = (mq_n[i] == p_depth[i]);
        take = (mf_n[i] == 0) && (mq_n[i] > 0);
        if (take) begin
            w = mq[i][0];
            for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
            mq_n[i] = mq_n[i] - 1;
            for (int j = 0; j < 24; j++) fb[j] = 1'b0;
            n = 0;
            fb[n] = 1'b0;
            n = n + 1;
            for (int b = 0; b < 8; b++) begin
                fb[n] = p_lsb[i] ? w[b] : w[7-b];
                n = n + 1;
            end
            if (mode != 2'b00) begin
                fb[n] = (mode == 2'b01) ? (^w) : (mode == 2'b10) ? (~^w) : 1'b1;
                n = n + 1;
            end
            for (int s = 0; s < p_stop[i]; s++) begin
                fb[n] = 1'b1;
                n = n + 1;
            end
            for (int j = 0; j < 24; j++) mf[i][j] = fb[j];
            mf_n[i] = n;
        end
        if (wr) begin
            if (full) m_ovf[i] = 1'b1;
            else begin
                mq[i][mq_n[i]] = din;
                mq_n[i] = mq_n[i] + 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mq_n[i]  = 0;
                mf_n[i]  = 0;
                m_ovf[i] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [10:0] act;
            logic [10:0] exp;
            if (i == 0) act = {ser_a, busy_a, full_a, empty_a, ovf_a, done_a, 2'b00, lvl_a};
            else        act = {ser_b, busy_b, full_b, empty_b, ovf_b, done_b, lvl_b};
            exp = {(mf_n[i] > 0) ? mf[i][0] : 1'b1, mf_n[i] > 0, mq_n[i] == p_depth[i],
                   mq_n[i] == 0, m_ovf[i], mf_n[i] == 1, 5'(mq_n[i])};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t ser/busy/full/empty/ovf/done/lvl actual=%b expected=%b",
                         i, $time, act, exp);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    logic [63:0] cap_ser_a, cap_ser_b, cap_mser_a, cap_busy_a, cap_done_a, cap_full_a;
    int          cap_lvl_a [64];

    // Sample j shows the state after edge j-1; inputs set in iteration j act on edge j.
    // Words are written on edges 0..nw-1, so the first start bit appears at sample 2.
    task automatic run(input logic [7:0] d0, input int nw, input logic [1:0] m,
                       input bit flip, input int n);
        cap_ser_a  = '0; cap_ser_b  = '0; cap_mser_a = '0;
        cap_busy_a = '0; cap_done_a = '0; cap_full_a = '0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            cap_ser_a[j]  = ser_a;
            cap_ser_b[j]  = ser_b;
            cap_mser_a[j] = (mf_n[0] > 0) ? mf[0][0] : 1'b1;
            cap_busy_a[j] = busy_a;
            cap_done_a[j] = done_a;
            cap_full_a[j] = full_a;
            cap_lvl_a[j]  = int'(lvl_a);
            if (j == 0) mode = m;
            if (flip && j == 2) mode = m ^ 2'b11;
            wr  = (j < nw);
            din = d0 + 8'(j * 17);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy_a == 1'b0 && busy_b == 1'b0 && empty_a && empty_b) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", longint'(n < 300), 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int busy_seen;

    initial begin
        rst  = 1'b1;
        wr   = 1'b0;
        din  = 8'h00;
        mode = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_serial", ser_a, 1);
        chk("rst_busy",   busy_a, 0);
        chk("rst_empty",  empty_a, 1);
        chk("rst_level",  lvl_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5, no parity, mode flipped to mark mid-frame must not add a parity bit
        run(8'hA5, 1, 2'b00, 1'b1, 14);
        chk("a5_latency_idle", cap_busy_a[1], 0);
        chk("a5_frame",        longint'((cap_ser_a  >> 2) & 64'h3FF), 'h34A);
        chk("a5_model_frame",  longint'((cap_mser_a >> 2) & 64'h3FF), 'h34A);
        chk("a5_word_done",    longint'((cap_done_a >> 2) & 64'h3FF), 'h200);
        chk("a5_busy_last",    cap_busy_a[11], 1);
        chk("a5_busy_after",   cap_busy_a[12], 0);
        wait_idle();

        // 0x07 with even / odd / mark parity, 11-cycle frames
        run(8'h07, 1, 2'b01, 1'b1, 15);
        chk("even_frame",      longint'((cap_ser_a >> 2) & 64'h7FF), 'h60E);
        chk("even_len_busy",   cap_busy_a[12], 1);
        chk("even_len_end",    cap_busy_a[13], 0);
        wait_idle();
        run(8'h07, 1, 2'b10, 1'b1, 15);
        chk("odd_frame",       longint'((cap_ser_a >> 2) & 64'h7FF), 'h40E);
        wait_idle();
        run(8'h07, 1, 2'b11, 1'b1, 15);
        chk("mark_frame",      longint'((cap_ser_a >> 2) & 64'h7FF), 'h60E);
        wait_idle();

        // three words back to back
        run(8'h11, 3, 2'b00, 1'b0, 34);
        chk("b2b_level_2",     cap_lvl_a[3], 2);
        chk("b2b_level_1",     cap_lvl_a[12], 1);
        chk("b2b_level_0",     cap_lvl_a[22], 0);
        chk("b2b_starts",      {cap_ser_a[22], cap_ser_a[12], cap_ser_a[2]}, 0);
        chk("b2b_no_gap",      longint'((cap_busy_a >> 2) & 64'h3FFF_FFFF), 'h3FFF_FFFF);
        chk("b2b_end",         cap_busy_a[32], 0);
        wait_idle();

        // six writes into depth-4 FIFO: one dropped, five frames
        run(8'h01, 6, 2'b00, 1'b0, 60);
        chk("ovf_first_pop",   cap_lvl_a[2], 1);
        chk("ovf_full_seen",   |cap_full_a, 1);
        chk("ovf_frames",      $countones(cap_done_a), 5);
        chk("ovf_flag_a",      ovf_a, 1);
        chk("ovf_flag_b",      ovf_b, 0);
        wait_idle();
        chk("ovf_sticky",      ovf_a, 1);

        // reset during data bit 3 of the first of three queued words
        run(8'h11, 3, 2'b00, 1'b0, 7);
        chk("rst_mid_bit3",    cap_ser_a[6], 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_serial_a", ser_a, 1);
        chk("rst_mid_serial_b", ser_b, 1);
        chk("rst_mid_level",   lvl_a, 0);
        chk("rst_mid_busy",    busy_a, 0);
        chk("rst_mid_ovf",     ovf_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a || busy_b) busy_seen++;
        end
        chk("rst_no_resume",   busy_seen, 0);

        // 0x80: MSB first with two stop bits on dut_b, LSB first on dut_a
        run(8'h80, 1, 2'b00, 1'b0, 16);
        chk("msb_first_frame", longint'((cap_ser_b >> 2) & 64'h7FF), 'h602);
        chk("lsb_first_frame", longint'((cap_ser_a >> 2) & 64'h3FF), 'h300);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
